// File: rtl/avalon_pio_poller_pkg.sv
// ============================================================================
// Module      : avalon_pio_poller_pkg
// Description : Shared types and constants for Avalon PIO polling initiators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package avalon_pio_poller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_CAPT = 2'd3
    } poll_state_t;

    // Word offset of the data register in a standard PIO responder.
    localparam logic [1:0] c_PIO_DATA_OFFSET = 2'd0;

endpackage

`default_nettype wire

// File: rtl/avalon_pio_poller_timer.sv
// ============================================================================
// Module      : pio_poll_timer
// Description : Free-running 0..PERIOD-1 wrap counter, held at 0 while
//               disabled; o_tick marks the last count of each period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_poll_timer #(
    parameter int PERIOD = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_tick
);

    localparam int              c_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(PERIOD - 1);

    logic [c_W-1:0] r_count;
    logic           w_last;

    assign w_last = (r_count == c_LAST);
    assign o_tick = i_enable && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!i_enable || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/avalon_pio_poller.sv
// ============================================================================
// Module      : avalon_pio_poller
// Description : Periodic Avalon-MM reader of a PIO data register with
//               change detection on the captured low DATA_WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_pio_poller
    import avalon_pio_poller_pkg::*;
#(
    parameter int         DATA_WIDTH   = 10,
    parameter int         POLL_PERIOD  = 50000,
    parameter int         READ_LATENCY = 1,
    parameter logic [1:0] POLL_ADDR    = c_PIO_DATA_OFFSET
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [31:0]           avm_readdata,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  value_valid,
    output logic                  changed,
    output logic [DATA_WIDTH-1:0] change_mask
);

    poll_state_t           r_state;
    logic [2:0]            r_lat;
    logic                  r_read;
    logic [DATA_WIDTH-1:0] r_value;
    logic                  r_valid;
    logic                  r_changed;
    logic [DATA_WIDTH-1:0] r_mask;
    logic                  w_tick;
    logic [DATA_WIDTH-1:0] w_sample;
    logic                  w_unused;

    assign w_sample    = avm_readdata[DATA_WIDTH-1:0];
    assign w_unused    = ^avm_readdata;
    assign avm_address = POLL_ADDR;
    assign avm_read    = r_read;
    assign value       = r_value;
    assign value_valid = r_valid;
    assign changed     = r_changed;
    assign change_mask = r_mask;

    pio_poll_timer #(
        .PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst      (reset),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

    // Sampling happens on the WAIT->CAPT edge, i.e. in the cycle that lies
    // READ_LATENCY cycles after acceptance; CAPT is the cycle where the
    // change pulse is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_lat     <= 3'd0;
            r_read    <= 1'b0;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_mask    <= '0;
        end else begin
            r_changed <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_REQ;
                        r_read  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_lat   <= 3'(READ_LATENCY);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_lat <= r_lat - 3'd1;
                    if (r_lat == 3'd1) begin
                        r_state <= ST_CAPT;
                        r_value <= w_sample;
                        r_valid <= 1'b1;
                        if (r_valid && (w_sample != r_value)) begin
                            r_changed <= 1'b1;
                            r_mask    <= w_sample ^ r_value;
                        end
                    end
                end
                ST_CAPT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_read  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_avalon_pio_poller.sv
// ============================================================================
// Module      : tb_avalon_pio_poller
// Description : Self-checking bench for avalon_pio_poller with a fixed-latency
//               PIO responder model and a poll-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_avalon_pio_poller;

    localparam int         DW   = 10;
    localparam int         P    = 16;
    localparam int         L    = 3;
    localparam logic [1:0] ADDR = 2'd0;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          avm_waitrequest;
    logic [31:0]   avm_readdata;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic [DW-1:0] value;
    logic          value_valid;
    logic          changed;
    logic [DW-1:0] change_mask;

    avalon_pio_poller #(
        .DATA_WIDTH   (DW),
        .POLL_PERIOD  (P),
        .READ_LATENCY (L),
        .POLL_ADDR    (ADDR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .value           (value),
        .value_valid     (value_valid),
        .changed         (changed),
        .change_mask     (change_mask)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            pend    = 0;
    logic [DW-1:0] in_port = '0;

    // Poll-level reference: last captured sample, whether one exists, held mask.
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_value = '0;
    logic [DW-1:0] m_mask  = '0;
    int            last_start = -1;

    typedef struct {
        logic [DW-1:0] sw;
        int            stall;
        logic          exp_chg;
        logic [DW-1:0] exp_mask;
    } vec_t;

    vec_t tbl [7];

    always @(posedge clk) cyc++;

    // Responder: read data is valid only in the cycle L cycles after acceptance.
    always @(posedge clk) begin
        logic [31:0] r;
        if (reset) pend = 0;
        else if (avm_read && !avm_waitrequest) pend = L;
        else if (pend != 0) pend = pend - 1;
        #1;
        r = $urandom();
        avm_readdata = (pend == 1) ? {r[31:DW], in_port} : r;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_poll(input logic [DW-1:0] sw, input int stall, input bit drop_en,
                           input bit use_tbl, input logic t_chg, input logic [DW-1:0] t_mask);
        logic          exp_chg;
        logic [DW-1:0] exp_mask;
        int            guard;
        in_port = sw;
        guard = 0;
        while (avm_read !== 1'b1 && guard < 3 * P) begin
            tick();
            guard++;
        end
        if (avm_read !== 1'b1) begin
            chk("poll_start_timeout", 32'd0, 32'd1);
            return;
        end
        if (last_start >= 0) chk("poll_spacing", cyc - last_start, P);
        last_start = cyc;
        if (drop_en) begin
            enable = 1'b0;
            last_start = -1;
        end
        for (int i = 0; i < stall; i++) begin
            avm_waitrequest = 1'b1;
            chk("stall_read", avm_read, 1);
            chk("stall_addr", avm_address, ADDR);
            tick();
        end
        avm_waitrequest = 1'b0;
        chk("accept_read", avm_read, 1);
        tick();
        chk("read_drop", avm_read, 0);
        for (int i = 0; i < L; i++) begin
            chk("no_early_change", changed, 0);
            tick();
        end
        exp_chg = m_valid && (sw != m_value);
        if (exp_chg) m_mask = sw ^ m_value;
        m_value = sw;
        m_valid = 1'b1;
        exp_mask = m_mask;
        if (use_tbl) begin
            exp_chg  = t_chg;
            exp_mask = t_mask;
        end
        chk("capt_value", value, sw);
        chk("capt_valid", value_valid, 1);
        chk("capt_changed", changed, exp_chg);
        chk("capt_mask", change_mask, exp_mask);
        tick();
        chk("changed_one_cycle", changed, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read"}, avm_read, 0);
        chk({tag, "_addr"}, avm_address, ADDR);
        chk({tag, "_value"}, value, 0);
        chk({tag, "_valid"}, value_valid, 0);
        chk({tag, "_changed"}, changed, 0);
        chk({tag, "_mask"}, change_mask, 0);
    endtask

    initial begin
        int seen;
        int n;
        int guard;
        tbl[0] = '{10'h02A, 0,  1'b0, 10'h000};
        tbl[1] = '{10'h02A, 0,  1'b0, 10'h000};
        tbl[2] = '{10'h02B, 0,  1'b1, 10'h001};
        tbl[3] = '{10'h02B, 5,  1'b0, 10'h001};
        tbl[4] = '{10'h3FF, 2,  1'b1, 10'h3D4};
        tbl[5] = '{10'h000, 10, 1'b1, 10'h3FF};
        tbl[6] = '{10'h000, 0,  1'b0, 10'h3FF};

        reset = 1'b1;
        enable = 1'b0;
        avm_waitrequest = 1'b0;
        #1;
        chk_reset_outputs("por");
        tick();
        tick();
        reset = 1'b0;
        enable = 1'b1;

        foreach (tbl[k]) do_poll(tbl[k].sw, tbl[k].stall, 1'b0, 1'b1, tbl[k].exp_chg, tbl[k].exp_mask);

        // Enable dropped while the read is pending: read still completes.
        do_poll(10'h155, 3, 1'b1, 1'b0, 1'b0, '0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (avm_read) seen++;
            tick();
        end
        chk("no_poll_disabled", seen, 0);
        enable = 1'b1;
        n = 0;
        while (avm_read !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("reenable_delay", n, P);
        do_poll(10'h0F0, 0, 1'b0, 1'b0, 1'b0, '0);

        // Reset asserted in the middle of WAIT.
        guard = 0;
        while (avm_read !== 1'b1 && guard < 3 * P) begin
            tick();
            guard++;
        end
        chk("rst_seq_start", avm_read, 1);
        avm_waitrequest = 1'b0;
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        tick();
        chk_reset_outputs("held_rst");
        reset = 1'b0;
        m_valid = 1'b0;
        m_value = '0;
        m_mask = '0;
        last_start = -1;
        do_poll(10'h2AA, 1, 1'b0, 1'b0, 1'b0, '0);
        do_poll(10'h2AB, 0, 1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 30; i++) begin
            logic [DW-1:0] sw;
            sw = ($urandom_range(0, 1) == 1) ? m_value : DW'($urandom());
            do_poll(sw, $urandom_range(0, 10), 1'b0, 1'b0, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
